// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the pipelined register file:
//   - default register width and address width
//   - number of read ports
//   - byteMerge(): combines an old word and a new word under a per-byte mask
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned NUM_READ_PORTS = 2;

    // byteMerge works on the widest supported word; callers zero-extend their
    // operands and truncate the result back to their own DATA_W.
    localparam int unsigned MAX_W     = 256;
    localparam int unsigned MAX_BYTES = MAX_W / 8;

    // Byte i of the result comes from newWord when mask[i] is set, else from oldWord.
    function automatic logic [MAX_W-1:0] byteMerge(
        input logic [MAX_W-1:0]     oldWord,
        input logic [MAX_W-1:0]     newWord,
        input logic [MAX_BYTES-1:0] mask
    );
        logic [MAX_W-1:0] merged;
        merged = oldWord;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (mask[i]) begin
                merged[i*8 +: 8] = newWord[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/pipelined_register_file_if.sv
// pipelined_register_file_if
// Groups the request and response signals of the pipelined register file.
//   master : drives read/write/issue requests, receives read data and busy flags
//   slave  : the register file itself
// Signals:
//   ReadRegister1/2, ReadEnable          read request (sampled at posedge)
//   WriteRegister, WriteData, RegWrite,
//   ByteEnable                           byte-masked write request
//   IssueRegister, IssueValid            marks a register as pending a write
//   ReadData1/2, ReadValid, Busy1/2      registered read response
interface pipelined_register_file_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

    logic [ADDR_W-1:0]   ReadRegister1;
    logic [ADDR_W-1:0]   ReadRegister2;
    logic                ReadEnable;
    logic [ADDR_W-1:0]   WriteRegister;
    logic [DATA_W-1:0]   WriteData;
    logic                RegWrite;
    logic [DATA_W/8-1:0] ByteEnable;
    logic [ADDR_W-1:0]   IssueRegister;
    logic                IssueValid;

    logic [DATA_W-1:0]   ReadData1;
    logic [DATA_W-1:0]   ReadData2;
    logic                ReadValid;
    logic                Busy1;
    logic                Busy2;

    modport master (
        output ReadRegister1, ReadRegister2, ReadEnable,
        output WriteRegister, WriteData, RegWrite, ByteEnable,
        output IssueRegister, IssueValid,
        input  ReadData1, ReadData2, ReadValid, Busy1, Busy2
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, ReadEnable,
        input  WriteRegister, WriteData, RegWrite, ByteEnable,
        input  IssueRegister, IssueValid,
        output ReadData1, ReadData2, ReadValid, Busy1, Busy2
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One busy bit per register. A set request marks a register pending, a clear
// request (a completed write) releases it; when both hit the same register in
// the same cycle the set wins. Lookups return the post-update value so that
// the caller sees the same view as a write-first data bypass.
// Ports:
//   Clk, Rst                     clock, asynchronous active-high reset
//   setValid, setAddr            issue: mark setAddr busy
//   clearValid, clearAddr        write: mark clearAddr not busy
//   lookupAddr1/2                addresses to look up
//   lookupBusy1/2                busy bit after this edge's set/clear update
module regfile_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              setValid,
    input  logic [ADDR_W-1:0] setAddr,
    input  logic              clearValid,
    input  logic [ADDR_W-1:0] clearAddr,
    input  logic [ADDR_W-1:0] lookupAddr1,
    input  logic [ADDR_W-1:0] lookupAddr2,
    output logic              lookupBusy1,
    output logic              lookupBusy2
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busyQ;
    logic [NREGS-1:0] busyD;

    always_comb begin
        busyD = busyQ;
        if (clearValid) begin
            busyD[clearAddr] = 1'b0;
        end
        // Applied after the clear so that issue wins over write; the hardwired
        // zero register can never become pending.
        if (setValid && !(ZERO_REG && (setAddr == '0))) begin
            busyD[setAddr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busyQ <= '0;
        end else begin
            busyQ <= busyD;
        end
    end

    assign lookupBusy1 = busyD[lookupAddr1];
    assign lookupBusy2 = busyD[lookupAddr2];

endmodule

// File: rtl/pipelined_register_file.sv
// pipelined_register_file
// Two-read, one-write register file with byte-masked writes, a write-first
// bypass, registered (1-cycle latency) read outputs and a per-register
// pending-write scoreboard.
// Parameters:
//   DATA_W    register width in bits (multiple of 8)
//   ADDR_W    address width, NREGS = 2**ADDR_W
//   ZERO_REG  when 1, register 0 reads as zero, ignores writes, is never busy
// Ports:
//   Clk       clock, all state updates on posedge
//   Rst       asynchronous active-high reset
//   bus       pipelined_register_file_if slave modport (requests in, read data out)
module pipelined_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                      Clk,
    input logic                      Rst,
    pipelined_register_file_if.slave bus
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    logic              writeEn;
    logic [DATA_W-1:0] writeMerged;

    logic [ADDR_W-1:0] rdAddr      [NUM_READ_PORTS];
    logic [DATA_W-1:0] rdDataD     [NUM_READ_PORTS];
    logic              rdBusyD     [NUM_READ_PORTS];
    logic [DATA_W-1:0] readDataQ   [NUM_READ_PORTS];
    logic              readBusyQ   [NUM_READ_PORTS];
    logic              readValidQ;

    assign rdAddr[0] = bus.ReadRegister1;
    assign rdAddr[1] = bus.ReadRegister2;

    // Write path: writes to the hardwired zero register are dropped entirely,
    // so they neither update storage nor feed the bypass.
    always_comb begin
        writeEn     = bus.RegWrite && !(ZERO_REG && (bus.WriteRegister == '0));
        writeMerged = DATA_W'(byteMerge(MAX_W'(regs[bus.WriteRegister]),
                                        MAX_W'(bus.WriteData),
                                        MAX_BYTES'(bus.ByteEnable)));
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[bus.WriteRegister] <= writeMerged;
        end
    end

    // Read-side next values: same-edge writes are forwarded (write-first).
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rdDataD[p] = regs[rdAddr[p]];
            if (ZERO_REG && (rdAddr[p] == '0)) begin
                rdDataD[p] = '0;
            end else if (writeEn && (bus.WriteRegister == rdAddr[p])) begin
                rdDataD[p] = writeMerged;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .Clk         (Clk),
        .Rst         (Rst),
        .setValid    (bus.IssueValid),
        .setAddr     (bus.IssueRegister),
        .clearValid  (bus.RegWrite),
        .clearAddr   (bus.WriteRegister),
        .lookupAddr1 (rdAddr[0]),
        .lookupAddr2 (rdAddr[1]),
        .lookupBusy1 (rdBusyD[0]),
        .lookupBusy2 (rdBusyD[1])
    );

    // Output registers: captured only on a read strobe, otherwise held.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            readValidQ <= 1'b0;
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                readDataQ[p] <= '0;
                readBusyQ[p] <= 1'b0;
            end
        end else begin
            readValidQ <= bus.ReadEnable;
            if (bus.ReadEnable) begin
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                    readDataQ[p] <= rdDataD[p];
                    readBusyQ[p] <= rdBusyD[p];
                end
            end
        end
    end

    assign bus.ReadData1 = readDataQ[0];
    assign bus.ReadData2 = readDataQ[1];
    assign bus.Busy1     = readBusyQ[0];
    assign bus.Busy2     = readBusyQ[1];
    assign bus.ReadValid = readValidQ;

endmodule

// File: doc/pipelined_register_file.md
PIPELINED_REGISTER_FILE -- requirements
Module: pipelined_register_file

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning register width in bits (multiple of 8).
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning address width; depth is NREGS = 2**ADDR_W.
REQ-003 The module SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-005 Clk  input  1  single clock; all state updates on posedge.
REQ-006 Rst  input  1  asynchronous, active-high reset.
REQ-007 ReadRegister1, ReadRegister2  input  ADDR_W  read addresses.
REQ-008 ReadEnable  input  1  read strobe, sampled at posedge.
REQ-009 WriteRegister  input  ADDR_W  write address.
REQ-010 WriteData  input  DATA_W  write data.
REQ-011 RegWrite  input  1  write strobe, sampled at posedge.
REQ-012 ByteEnable  input  DATA_W/8  per-byte write mask.
REQ-013 IssueRegister  input  ADDR_W  destination register of a newly issued instruction.
REQ-014 IssueValid  input  1  marks IssueRegister as pending.
REQ-015 ReadData1, ReadData2  output  DATA_W  registered read data.
REQ-016 ReadValid  output  1  one-cycle pulse; read data is valid.
REQ-017 Busy1, Busy2  output  1  registered pending-write flags for the read addresses.

Function
REQ-018 The write SHALL occur at posedge Clk when RegWrite=1; only bytes with ByteEnable[i]=1 SHALL update, and all other bytes SHALL hold.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be ignored; reads of address 0 SHALL return 0; and address 0 SHALL never be busy.
REQ-020 Read latency SHALL be 1 cycle: at a posedge with ReadEnable=1, ReadDataN SHALL capture the register contents, and ReadValid SHALL be 1 for the following cycle only.
REQ-021 When ReadEnable=0, ReadData1/2 and Busy1/2 SHALL hold their previous values, and ReadValid SHALL be 0.
REQ-022 Write-first bypass: if RegWrite=1 and WriteRegister equals ReadRegisterN at the same edge, ReadDataN SHALL return the byte-merged new value (old bytes where ByteEnable=0).
REQ-023 Both read ports with the same address SHALL return identical data.
REQ-024 Scoreboard: each register SHALL have one busy bit; IssueValid=1 SHALL set busy[IssueRegister], and RegWrite=1 SHALL clear busy[WriteRegister].
REQ-025 Simultaneous issue and write to the same register SHALL leave the busy bit set (set wins).
REQ-026 Busy1/Busy2 SHALL report the busy bit value after the same edge's set/clear update, consistent with the bypass rule.
REQ-027 A write to a non-busy register SHALL be legal and SHALL leave the bit clear.
REQ-028 Register contents SHALL be unaffected by issue operations.

Reset
REQ-029 While Rst=1, all registers SHALL be 0, all busy bits 0, ReadData1/2 = 0, Busy1/2 = 0, and ReadValid = 0, regardless of Clk.
REQ-030 Reset asserted mid-operation SHALL discard any read in flight (no ReadValid pulse) and all pending flags.
REQ-031 The first operation SHALL be accepted at the first posedge after Rst deasserts.

Structure
REQ-032 The DATA_W/ADDR_W defaults and a byte-merge function (old, new, mask -> merged) SHALL live in shared package regfile_pkg.
REQ-033 The busy-bit array and its set/clear/lookup logic SHALL be a sub-module named regfile_scoreboard.
REQ-034 The storage array SHALL not be reset-gated per entry beyond REQ-029, and SHALL have no read-side combinational path to the outputs.

Verification
REQ-035 Write 0xDEADBEEF to r5 with ByteEnable=1111, then read r5 -> ReadData1=0xDEADBEEF with a ReadValid pulse 1 cycle later.
REQ-036 With r5=0xDEADBEEF, write 0x11223344 to r5 with ByteEnable=0101 while reading r5 in the same cycle -> ReadData1=0xDE22BE44.
REQ-037 Write 0xFFFFFFFF to r0, then read r0 on both ports -> both ports return 0 and Busy=0; issuing r0 -> Busy stays 0.
REQ-038 Issue r7, then read r7 -> Busy1=1; write r7 together with a read -> Busy1=0; issue and write r7 in the same cycle -> Busy1=1.
REQ-039 Assert Rst mid-read after r3=0x5A -> outputs 0, no ReadValid; after release, read r3 -> 0.
REQ-040 Run a random issue/write/read sequence against a reference model for 10000 cycles with DATA_W=64 and ADDR_W=4 -> zero mismatches.
